// File: rtl/uart_pkg.sv
// Shared types and constants for the extended UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP1    = 3'd4,
        ST_STOP2    = 3'd5,
        ST_BRK_WAIT = 3'd6
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_DATA_BITS = 5;

    function automatic int mid_of(input int oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, start-edge detect, per-bit oversample counter and 3-sample majority vote.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_en,
    input  logic rx,
    input  logic restart,
    input  logic active,
    output logic line,
    output logic start_edge,
    output logic bit_strobe,
    output logic bit_val,
    output logic bit_end
);

    localparam int MID = mid_of(OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);

    logic          sync_a;
    logic          prev;
    logic [CW-1:0] cnt;
    logic          s_early;
    logic          s_mid;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchroniser flops preset to idle-high so reset can never look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            line   <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_a <= rx;
            line   <= sync_a;
            prev   <= line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (active && baud_en) begin
            cnt <= (cnt == CW'(OVERSAMPLE - 1)) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (baud_en && cnt == CW'(MID - 1)) s_early <= line;
        if (baud_en && cnt == CW'(MID))     s_mid   <= line;
    end

    assign start_edge = prev & ~line;
    assign bit_strobe = active && baud_en && (cnt == CW'(MID + 1));
    assign bit_end    = active && baud_en && (cnt == CW'(OVERSAMPLE - 1));
    assign bit_val    = majority3(s_early, s_mid, line);

endmodule

// File: rtl/uart_rx_ext.sv
// Runtime-configurable UART receiver: frame FSM, shift register, one-entry holding register and flags.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_en,
    input  logic                  rx,
    input  logic [3:0]            cfg_data_bits,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_rdy,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun,
    input  logic                  ovr_clr,
    output logic                  rx_busy
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    state_t                state;
    logic [BW-1:0]         nbits;
    logic [BW-1:0]         bit_idx;
    logic                  par_en;
    logic                  par_odd;
    logic                  stop2;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr;
    logic                  ferr;
    logic                  all_zero;

    logic line, start_edge, bit_strobe, bit_val, bit_end;
    logic take_start, active, complete, brk, ferr_now;

    function automatic logic [BW-1:0] clamp_bits(input logic [3:0] req);
        if (req < 4'(MIN_DATA_BITS)) return BW'(MIN_DATA_BITS);
        else if (req > 4'(DATA_WIDTH)) return BW'(DATA_WIDTH);
        else return BW'(req);
    endfunction

    assign take_start = (state == ST_IDLE) && start_edge;
    assign active     = (state != ST_IDLE) && (state != ST_BRK_WAIT);
    assign rx_busy    = active;
    assign ferr_now   = ferr | ~bit_val;

    uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_en    (baud_en),
        .rx         (rx),
        .restart    (take_start),
        .active     (active),
        .line       (line),
        .start_edge (start_edge),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val),
        .bit_end    (bit_end)
    );

    // A single-stop frame completes at its decision point so a following start edge is not missed.
    always_comb begin
        complete = 1'b0;
        brk      = 1'b0;
        if (bit_strobe && state == ST_STOP1) begin
            if (all_zero && !bit_val) brk = 1'b1;
            else if (!stop2)          complete = 1'b1;
        end
        if (bit_strobe && state == ST_STOP2) complete = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            nbits    <= BW'(MIN_DATA_BITS);
            bit_idx  <= '0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            stop2    <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            all_zero <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (start_edge) begin
                    state    <= ST_START;
                    nbits    <= clamp_bits(cfg_data_bits);
                    par_en   <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                    par_odd  <= (cfg_parity == PAR_ODD);
                    stop2    <= cfg_stop2;
                    bit_idx  <= '0;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                    all_zero <= 1'b1;
                end
                ST_START: begin
                    if (bit_strobe && bit_val) state <= ST_IDLE;
                    else if (bit_end)          state <= ST_DATA;
                end
                ST_DATA: if (bit_strobe) begin
                    all_zero <= all_zero & ~bit_val;
                    if (bit_idx == nbits - 1'b1) state <= par_en ? ST_PARITY : ST_STOP1;
                    else                         bit_idx <= bit_idx + 1'b1;
                end
                ST_PARITY: if (bit_strobe) begin
                    perr     <= bit_val != (par_odd ? ~^shreg : ^shreg);
                    all_zero <= all_zero & ~bit_val;
                    state    <= ST_STOP1;
                end
                ST_STOP1: if (bit_strobe) begin
                    ferr <= ferr_now;
                    if (brk)        state <= ST_BRK_WAIT;
                    else if (stop2) state <= ST_STOP2;
                    else            state <= ST_IDLE;
                end
                ST_STOP2: if (bit_strobe) begin
                    ferr  <= ferr_now;
                    state <= ST_IDLE;
                end
                ST_BRK_WAIT: if (line) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bits land at their own index, so unused upper bits stay 0 and parity covers only real data.
    always_ff @(posedge clk) begin
        if (take_start) begin
            shreg <= '0;
        end else if (state == ST_DATA && bit_strobe) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (BW'(i) == bit_idx) shreg[i] <= bit_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            break_det <= brk;
            if (complete && (!rx_valid || rx_rdy)) begin
                rx_data    <= shreg;
                parity_err <= perr;
                frame_err  <= ferr_now;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_rdy) begin
                rx_valid <= 1'b0;
            end
            if (complete && rx_valid && !rx_rdy) overrun <= 1'b1;
            else if (ovr_clr)                    overrun <= 1'b0;
        end
    end

endmodule
